// File: rtl/uc_tile_host_seq.sv
// Host sequencer around the uC tile: holds flash/SRAM and single-steps the uC in 3-clock steps.
// Optional breakpoint stop is enabled by defining UC_HOST_BKPT_EN.
module uc_tile_host_seq #(
    parameter int FLASH_DEPTH = 256,
    parameter int SRAM_DEPTH  = 256
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        halt_req,
    input  logic [31:0] tile_reg_c,
    output logic [31:0] tile_reg_a,
    output logic [31:0] tile_reg_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] step_count,
    input  logic [11:0] bkpt_addr,
    output logic        bkpt_hit,
    output logic [1:0]  dbg_state
);
    localparam int FAW = (FLASH_DEPTH > 1) ? $clog2(FLASH_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_SETUP = 2'd2;
    localparam logic [1:0] ST_HIGH  = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_WSRAM = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;

    logic [15:0] flash_mem [FLASH_DEPTH];
    logic [7:0]  sram_mem  [SRAM_DEPTH];

    logic [1:0]  state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] step_q, step_d;
    logic        stepped_q, stepped_d;
    logic        done_q, done_d;
    logic        bkpt_q, bkpt_d;
    logic        ready_q;
    logic        we_q;
    logic [7:0]  waddr_q, wdata_q;
    logic [15:0] flash_rd_q;
    logic [7:0]  sram_rd_q;

    logic        cmd_fire, launch, bkpt_stop, pc_ok, flash_we, sram_cmd_we;
    logic [11:0] tile_pc;

    // Handshake: a command is taken on any cycle where cmd_valid and cmd_ready are both high.
    assign cmd_fire    = cmd_valid && ready_q;
    assign tile_pc     = tile_reg_c[27:16];
    assign pc_ok       = 32'(tile_pc) < FLASH_DEPTH;
    assign flash_we    = cmd_fire && (cmd_op == OP_LOAD) && (32'(cmd_addr) < FLASH_DEPTH);
    assign sram_cmd_we = cmd_fire && (cmd_op == OP_WSRAM);

`ifdef UC_HOST_BKPT_EN
    logic unused_ok;
    assign unused_ok = ^{tile_reg_c[31], tile_reg_c[29:28]};
    assign bkpt_stop = (state_q == ST_LOW) && stepped_q && (tile_pc == bkpt_addr);
`else
    logic unused_ok;
    assign unused_ok = ^{tile_reg_c[31], tile_reg_c[29:28], bkpt_addr, stepped_q};
    assign bkpt_stop = 1'b0;
`endif

    assign launch = (state_q == ST_LOW) && !bkpt_stop;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        step_d      = step_q;
        stepped_d   = stepped_q;
        done_d      = 1'b0;
        bkpt_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (cmd_op == OP_RUN)) begin
                    remaining_d = cmd_data;
                    stepped_d   = 1'b0;
                    if (cmd_data == 16'd0) done_d = 1'b1;
                    else                   state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (bkpt_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    bkpt_d  = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_HIGH;
            default: begin
                step_d      = step_q + 16'd1;
                remaining_d = remaining_q - 16'd1;
                stepped_d   = 1'b1;
                if ((remaining_q == 16'd1) || halt_req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOW;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            remaining_q <= 16'd0;
            step_q      <= 16'd0;
            stepped_q   <= 1'b0;
            done_q      <= 1'b0;
            bkpt_q      <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= 8'd0;
            wdata_q     <= 8'd0;
            flash_rd_q  <= 16'd0;
            sram_rd_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == ST_IDLE);
            remaining_q <= remaining_d;
            step_q      <= step_d;
            stepped_q   <= stepped_d;
            done_q      <= done_d;
            bkpt_q      <= bkpt_d;
            if (launch) begin
                we_q       <= tile_reg_c[30];
                waddr_q    <= tile_reg_c[7:0];
                wdata_q    <= tile_reg_c[15:8];
                flash_rd_q <= pc_ok ? flash_mem[tile_pc[FAW-1:0]] : 16'h0000;
                sram_rd_q  <= sram_mem[tile_reg_c[7:0]];
            end
        end
    end

    // Arrays are not reset; the async reset drops state to IDLE so no PH_HIGH write follows it.
    always_ff @(posedge clk) begin
        if (flash_we) flash_mem[cmd_addr[FAW-1:0]] <= cmd_data;
        if (sram_cmd_we)                       sram_mem[cmd_addr[7:0]] <= cmd_data[7:0];
        else if ((state_q == ST_HIGH) && we_q) sram_mem[waddr_q]       <= wdata_q;
    end

    assign cmd_ready  = ready_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign bkpt_hit   = bkpt_q;
    assign step_count = step_q;
    assign dbg_state  = state_q;
    assign tile_reg_a = {22'd0, (state_q == ST_HIGH), 1'b0, sram_rd_q};
    assign tile_reg_b = {16'd0, flash_rd_q};
endmodule

// File: tb/tb_uc_tile_host_seq.sv
// Bench for uc_tile_host_seq: directed vectors, scoreboard queues popped by a monitor.
module tb_uc_tile_host_seq;
  localparam logic [1:0] ST_SETUP = 2'd2;
  localparam logic [1:0] ST_HIGH  = 2'd3;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [11:0] cmd_addr = 12'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        halt_req = 1'b0;
  logic [31:0] tile_reg_c, tile_reg_a, tile_reg_b;
  logic        busy, done, bkpt_hit;
  logic [15:0] step_count;
  logic [11:0] bkpt_addr = 12'hABC;
  logic [1:0]  dbg_state;

  logic [31:0] tile_tab [16];
  int          pulse_cnt = 0;
  int          tbase = 0;
  logic [3:0]  tidx;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_steps = 0;
  logic [23:0] exp_setup_q[$];
  logic [16:0] exp_done_q[$];

  uc_tile_host_seq #(.FLASH_DEPTH(256), .SRAM_DEPTH(256)) dut (
    .clk(clk), .arst_n(arst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .halt_req(halt_req),
    .tile_reg_c(tile_reg_c), .tile_reg_a(tile_reg_a), .tile_reg_b(tile_reg_b),
    .busy(busy), .done(done), .step_count(step_count), .bkpt_addr(bkpt_addr),
    .bkpt_hit(bkpt_hit), .dbg_state(dbg_state)
  );

  // clock / tile model: tile_reg_c advances one table entry per uC clock pulse
  always #5 clk = ~clk;
  always @(posedge tile_reg_a[9]) pulse_cnt++;
  assign tidx = 4'(pulse_cnt - tbase);
  assign tile_reg_c = tile_tab[tidx];

  function automatic logic [31:0] rc(input logic we, input logic [11:0] pc,
                                     input logic [7:0] wd, input logic [7:0] ad);
    return {1'b0, we, 2'b00, pc, wd, ad};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_tab_all(input logic [31:0] v);
    for (int i = 0; i < 16; i++) tile_tab[i] = v;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [15:0] data);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_ready_timeout got=0 exp=1");
    end
    cmd_op = op;
    cmd_addr = addr;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic push_setup(input logic [15:0] w, input logic [7:0] b);
    exp_setup_q.push_back({w, b});
  endtask

  task automatic run_steps(input logic [15:0] n, input int halt_at, input int exp_pulses, input int exp_busy);
    int base, busy_cyc, setups;
    logic seen;
    tbase = pulse_cnt;
    base = pulse_cnt;
    busy_cyc = 0;
    setups = 0;
    seen = 1'b0;
    issue_cmd(2'd2, 12'd0, n);
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (dbg_state == ST_SETUP) begin
        setups++;
        if (setups == halt_at) halt_req = 1'b1;
      end
      if (done) seen = 1'b1;
    end
    halt_req = 1'b0;
    check("run_done_seen", 64'(seen), 64'd1);
    check("uc_pulses", 64'(pulse_cnt - base), 64'(exp_pulses));
    check("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
  endtask

  // scoreboard monitor: pops on every PH_SETUP cycle and every done pulse
  task automatic monitor();
    logic [23:0] es;
    logic [16:0] ed;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (dbg_state == ST_SETUP) begin
          if (exp_setup_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL setup_unexpected got_b=%h got_a=%h", tile_reg_b, tile_reg_a);
          end else begin
            es = exp_setup_q.pop_front();
            check("setup_data", {tile_reg_b, tile_reg_a}, {16'h0, es[23:8], 24'h0, es[7:0]});
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_unexpected got_steps=%0d", step_count);
          end else begin
            ed = exp_done_q.pop_front();
            check("done_bkpt_steps", 64'({bkpt_hit, step_count}), 64'(ed));
          end
        end else if (bkpt_hit) begin
          check("bkpt_without_done", 64'(bkpt_hit), 64'd0);
        end
      end
    end
  endtask

  initial begin
    int w;
    set_tab_all(32'd0);
    fork
      monitor();
    join_none

    // reset
    repeat (3) @(negedge clk);
    check("reset_regs", {tile_reg_a, tile_reg_b}, 64'd0);
    check("reset_ctrl", 64'({cmd_ready, busy, done, bkpt_hit, dbg_state, step_count}), 64'd0);
    arst_n = 1'b1;
    #1 check("ready_low_at_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'({cmd_ready, done, bkpt_hit}), 64'b100);

    // memory preload, dropped out-of-range flash write, reserved op
    issue_cmd(2'd0, 12'd0, 16'h1111);
    issue_cmd(2'd0, 12'd1, 16'h2222);
    issue_cmd(2'd0, 12'd2, 16'h3333);
    issue_cmd(2'd0, 12'd3, 16'h4444);
    issue_cmd(2'd1, 12'h010, 16'h00A5);
    issue_cmd(2'd1, 12'h020, 16'h0033);
    issue_cmd(2'd1, 12'h040, 16'h0077);
    issue_cmd(2'd0, 12'h100, 16'hBEEF);
    issue_cmd(2'd3, 12'd0, 16'hFFFF);
    @(negedge clk);
    check("reserved_op_idle", 64'({busy, cmd_ready, done}), 64'b010);

    // RUN 4, pc 0..3
    for (int i = 0; i < 16; i++) tile_tab[i] = rc(1'b0, 12'(i), 8'h00, 8'h10);
    push_setup(16'h1111, 8'hA5);
    push_setup(16'h2222, 8'hA5);
    push_setup(16'h3333, 8'hA5);
    push_setup(16'h4444, 8'hA5);
    exp_steps = 4;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd4, 0, 4, 12);

    // RUN 1 reading SRAM 0x10; flash[0] must not be hit by the 0x100 write
    set_tab_all(rc(1'b0, 12'd0, 8'h00, 8'h10));
    push_setup(16'h1111, 8'hA5);
    exp_steps = 5;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd1, 0, 1, 3);

    // write-through: step 0 writes 0x20 = 5A, step 1 reads it back
    set_tab_all(rc(1'b0, 12'd2, 8'h00, 8'h20));
    tile_tab[0] = rc(1'b1, 12'd1, 8'h5A, 8'h20);
    push_setup(16'h2222, 8'h33);
    push_setup(16'h3333, 8'h5A);
    exp_steps = 7;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd2, 0, 2, 6);

    // RUN 100 with halt raised in the third PH_SETUP
    set_tab_all(rc(1'b0, 12'd0, 8'h00, 8'h10));
    push_setup(16'h1111, 8'hA5);
    push_setup(16'h1111, 8'hA5);
    push_setup(16'h1111, 8'hA5);
    exp_steps = 10;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd100, 3, 3, 9);

    // RUN 0
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd0, 0, 0, 0);

    // pc beyond flash depth returns zero
    set_tab_all(rc(1'b0, 12'hFFF, 8'h00, 8'h10));
    push_setup(16'h0000, 8'hA5);
    exp_steps = 11;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd1, 0, 1, 3);

`ifdef UC_HOST_BKPT_EN
    // breakpoint at pc 3: three steps, then stop in PH_LOW
    bkpt_addr = 12'd3;
    for (int i = 0; i < 16; i++) tile_tab[i] = rc(1'b0, 12'(i % 6), 8'h00, 8'h10);
    push_setup(16'h1111, 8'hA5);
    push_setup(16'h2222, 8'hA5);
    push_setup(16'h3333, 8'hA5);
    exp_steps = 14;
    exp_done_q.push_back({1'b1, 16'(exp_steps)});
    run_steps(16'd10, 0, 3, 10);
    bkpt_addr = 12'hABC;
`endif

    // reset during PH_HIGH of a step that would write 0x40 = EE
    set_tab_all(rc(1'b1, 12'd0, 8'hEE, 8'h40));
    push_setup(16'h1111, 8'h77);
    tbase = pulse_cnt;
    issue_cmd(2'd2, 12'd0, 16'd5);
    w = 0;
    while (dbg_state != ST_HIGH && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("uc_clk_high_in_ph_high", 64'(tile_reg_a[9]), 64'd1);
    #1 arst_n = 1'b0;
    #1 check("uc_clk_drop_on_reset", 64'({tile_reg_a[9], busy, cmd_ready}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    exp_steps = 0;
    check("steps_after_reset", 64'(step_count), 64'd0);
    set_tab_all(rc(1'b0, 12'd0, 8'h00, 8'h40));
    push_setup(16'h1111, 8'h77);
    exp_steps = 1;
    exp_done_q.push_back({1'b0, 16'(exp_steps)});
    run_steps(16'd1, 0, 1, 3);

    repeat (5) @(negedge clk);
    check("setup_q_drained", 64'(exp_setup_q.size()), 64'd0);
    check("done_q_drained", 64'(exp_done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
